// File: rtl/display_share_arbiter.sv
// display_share_arbiter
//
// Shares one 16-bit hex display between two requesters (A and B). A
// requester that wins arbitration gets its number shown for at least
// HOLD_CYCLES clock cycles before the display can be handed to anyone else.
//
// Handshake: a requester raises valid and holds it (with a stable number)
// until it is acknowledged. The arbiter answers with a registered ready
// pulse of exactly one cycle. The transfer happens on the rising edge
// where valid and ready are both 1. If valid has been dropped by that
// edge, the offer is withdrawn and nothing is captured.
//
// Ports
//   i_clk                single clock
//   i_reset_n            asynchronous active-low reset
//   i_req_a_valid        requester A has a number to show
//   i_req_a_number[15:0] requester A number
//   o_req_a_ready        registered ready to requester A
//   i_req_b_valid        requester B has a number to show
//   i_req_b_number[15:0] requester B number
//   o_req_b_ready        registered ready to requester B
//   o_number_to_display  number sent to the hex display wrapper
//   o_owner              0 = A, 1 = B; owner of the current or last number
//   o_active             high while a hold window is running
//   o_state[1:0]         debug view of the FSM state (0 IDLE, 1 OFFER, 2 SHOW)

module display_share_arbiter #(
    parameter int HOLD_CYCLES = 25000000,
    parameter int HOLD_WIDTH  = 25
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req_a_valid,
    input  logic [15:0] i_req_a_number,
    output logic        o_req_a_ready,
    input  logic        i_req_b_valid,
    input  logic [15:0] i_req_b_number,
    output logic        o_req_b_ready,
    output logic [15:0] o_number_to_display,
    output logic        o_owner,
    output logic        o_active,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // The counter is loaded with HOLD_CYCLES-1 and SHOW exits on the edge
    // where it reads zero, so SHOW spans exactly HOLD_CYCLES cycles.
    localparam logic [HOLD_WIDTH-1:0] HOLD_LOAD = HOLD_WIDTH'(HOLD_CYCLES - 1);

    state_t                state;
    logic [HOLD_WIDTH-1:0] hold_cnt;
    logic                  last_owner;

    logic        pick_b;
    logic        offer_b;
    logic        win_valid;
    logic [15:0] win_number;

    // Round-robin: B wins when it is the only requester, or when both ask
    // and A owned the display last. last_owner resets to B so A wins the
    // first tie.
    assign pick_b = i_req_b_valid & (~i_req_a_valid | ~last_owner);

    // While in OFFER exactly one ready is high, so it names the winner.
    assign offer_b    = o_req_b_ready;
    assign win_valid  = offer_b ? i_req_b_valid  : i_req_a_valid;
    assign win_number = offer_b ? i_req_b_number : i_req_a_number;

    assign o_state = state;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state               <= ST_IDLE;
            hold_cnt            <= '0;
            last_owner          <= 1'b1;
            o_req_a_ready       <= 1'b0;
            o_req_b_ready       <= 1'b0;
            o_number_to_display <= 16'h0000;
            o_owner             <= 1'b0;
            o_active            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_a_valid || i_req_b_valid) begin
                        o_req_a_ready <= ~pick_b;
                        o_req_b_ready <= pick_b;
                        state         <= ST_OFFER;
                    end
                end

                ST_OFFER: begin
                    // Ready is a single-cycle pulse whether or not the
                    // winner is still there to take it.
                    o_req_a_ready <= 1'b0;
                    o_req_b_ready <= 1'b0;
                    state         <= ST_IDLE;
                    if (win_valid) begin
                        o_number_to_display <= win_number;
                        o_owner             <= offer_b;
                        last_owner          <= offer_b;
                        hold_cnt            <= HOLD_LOAD;
                        o_active            <= 1'b1;
                        state               <= ST_SHOW;
                    end
                end

                ST_SHOW: begin
                    // No arbitration here: pending requests wait for IDLE.
                    if (hold_cnt == '0) begin
                        o_active <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                default: begin
                    o_req_a_ready <= 1'b0;
                    o_req_b_ready <= 1'b0;
                    o_active      <= 1'b0;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Testbench for display_share_arbiter.
// Main instance uses HOLD_CYCLES = 8; a second instance uses HOLD_CYCLES = 1.
// Inputs are driven on the falling edge, outputs sampled on the falling edge.

module tb_display_share_arbiter;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_valid = 1'b0;
    logic [15:0] a_num = 16'h0;
    logic        b_valid = 1'b0;
    logic [15:0] b_num = 16'h0;
    logic        a_ready, b_ready, owner, active;
    logic [15:0] number;
    logic [1:0]  state;

    logic        a1_valid = 1'b0;
    logic [15:0] a1_num = 16'h0;
    logic        b1_valid = 1'b0;
    logic [15:0] b1_num = 16'h0;
    logic        a1_ready, b1_ready, owner1, active1;
    logic [15:0] number1;
    logic [1:0]  state1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    display_share_arbiter #(.HOLD_CYCLES(HOLD), .HOLD_WIDTH(4)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_a_valid(a_valid), .i_req_a_number(a_num), .o_req_a_ready(a_ready),
        .i_req_b_valid(b_valid), .i_req_b_number(b_num), .o_req_b_ready(b_ready),
        .o_number_to_display(number), .o_owner(owner), .o_active(active),
        .o_state(state)
    );

    display_share_arbiter #(.HOLD_CYCLES(1), .HOLD_WIDTH(4)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_a_valid(a1_valid), .i_req_a_number(a1_num), .o_req_a_ready(a1_ready),
        .i_req_b_valid(b1_valid), .i_req_b_number(b1_num), .o_req_b_ready(b1_ready),
        .o_number_to_display(number1), .o_owner(owner1), .o_active(active1),
        .o_state(state1)
    );

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a1_valid = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // ---------------- behavioural reference model ----------------
    // Tracks who is being offered the display (0 none, 1 A, 2 B) and how
    // many hold cycles remain; updated once per rising edge.
    int          m_offer;
    int          m_show_left;
    bit          m_last_b;
    logic [15:0] m_num;
    bit          m_owner;

    task automatic model_reset();
        m_offer = 0; m_show_left = 0; m_last_b = 1'b1; m_num = 16'h0; m_owner = 1'b0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (m_offer != 0) begin
            if ((m_offer == 1) ? a_valid : b_valid) begin
                m_num       = (m_offer == 1) ? a_num : b_num;
                m_owner     = (m_offer == 2);
                m_last_b    = m_owner;
                m_show_left = HOLD;
            end
            m_offer = 0;
        end else if (m_show_left > 0) begin
            m_show_left--;
        end else if (a_valid || b_valid) begin
            if (a_valid && b_valid) m_offer = m_last_b ? 1 : 2;
            else                    m_offer = a_valid ? 1 : 2;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        a_v;
        logic [15:0] a_n;
        logic        b_v;
        logic [15:0] b_n;
        logic        e_ra;
        logic        e_rb;
        logic [15:0] e_num;
        logic        e_own;
        logic        e_act;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int          t_cyc[$];
        logic [15:0] t_num[$];
        logic        t_own[$];
        logic        hist[$];
        logic        prev;
        int          overlap;

        // single request, hold window, no ack during SHOW, withdrawal, tie
        vecs[0]  = '{1'b1, 16'h12AB, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 16'h12AB, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 16'h3C4D, 1'b0, 1'b1, 16'h12AB, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h3C4D, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h12AB, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b1, 16'h12AB, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 16'h1111, 1'b1, 16'h2222, 1'b0, 1'b0, 16'h2222, 1'b1, 1'b1};

        // ---- reset state ----
        apply_reset();
        check("rst_number", 32'(number), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_active", 32'(active), 32'h0);
        check("rst_readies", {30'h0, a_ready, b_ready}, 32'h0);

        // ---- table ----
        for (int i = 0; i < 15; i++) begin
            a_valid = vecs[i].a_v; a_num = vecs[i].a_n;
            b_valid = vecs[i].b_v; b_num = vecs[i].b_n;
            cycle();
            check($sformatf("vec%0d_ready_a", i), 32'(a_ready), 32'(vecs[i].e_ra));
            check($sformatf("vec%0d_ready_b", i), 32'(b_ready), 32'(vecs[i].e_rb));
            check($sformatf("vec%0d_number", i), 32'(number), 32'(vecs[i].e_num));
            check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].e_own));
            check($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].e_act));
        end

        // ---- reset mid-SHOW is immediate ----
        apply_reset();
        a_valid = 1'b1; a_num = 16'hBEEF;
        for (int i = 0; i < 4; i++) cycle();
        check("pre_rst_show_active", 32'(active), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midshow_rst_number", 32'(number), 32'h0);
        check("midshow_rst_owner", 32'(owner), 32'h0);
        check("midshow_rst_active", 32'(active), 32'h0);
        check("midshow_rst_readies", {30'h0, a_ready, b_ready}, 32'h0);
        @(negedge clk);
        // ---- reset mid-OFFER aborts the transfer ----
        rst_n = 1'b1;
        cycle();
        check("offer_ready_a", 32'(a_ready), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midoffer_rst_ready_a", 32'(a_ready), 32'h0);
        @(negedge clk);
        a_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        check("midoffer_no_transfer", {15'h0, number, active}, 32'h0);

        // ---- tie after reset: A then B, 10 cycles apart ----
        apply_reset();
        a_valid = 1'b1; a_num = 16'h1111;
        b_valid = 1'b1; b_num = 16'h2222;
        prev = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (active && !prev) begin
                t_cyc.push_back(i); t_num.push_back(number); t_own.push_back(owner);
            end
            prev = active;
        end
        check("tie_transfers", 32'(t_cyc.size() >= 2), 32'h1);
        if (t_cyc.size() >= 2) begin
            check("tie_first_num", 32'(t_num[0]), 32'h1111);
            check("tie_first_owner", 32'(t_own[0]), 32'h0);
            check("tie_second_num", 32'(t_num[1]), 32'h2222);
            check("tie_second_owner", 32'(t_own[1]), 32'h1);
            check("tie_first_cycle", 32'(t_cyc[0]), 32'd2);
            check("tie_spacing", 32'(t_cyc[1] - t_cyc[0]), 32'd10);
        end

        // ---- starvation: both held for 100 cycles ----
        apply_reset();
        a_valid = 1'b1; a_num = 16'hAAAA;
        b_valid = 1'b1; b_num = 16'hBBBB;
        t_own.delete();
        prev = 1'b0;
        overlap = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if ((a_ready || b_ready) && active) overlap++;
            if (a_ready && b_ready) overlap++;
            if (active && !prev) t_own.push_back(owner);
            prev = active;
        end
        check("starve_ready_vs_active", 32'(overlap), 32'h0);
        check("starve_grant_count", 32'(t_own.size()), 32'd10);
        for (int i = 1; i < t_own.size(); i++)
            check($sformatf("starve_alternate%0d", i), 32'(t_own[i]), 32'(!t_own[i-1]));

        // ---- HOLD_CYCLES = 1 instance ----
        a_valid = 1'b0; b_valid = 1'b0;
        apply_reset();
        a1_valid = 1'b1; a1_num = 16'h7A7A;
        hist.delete();
        for (int i = 0; i < 30; i++) begin
            cycle();
            hist.push_back(active1);
        end
        a1_valid = 1'b0;
        t_cyc.delete();
        for (int i = 1; i < hist.size(); i++)
            if (hist[i] && !hist[i-1]) t_cyc.push_back(i);
        check("h1_first_rise", 32'(hist[1]), 32'h1);
        check("h1_number", 32'(number1), 32'h7A7A);
        check("h1_rise_count", 32'(t_cyc.size() >= 8), 32'h1);
        for (int i = 1; i < t_cyc.size(); i++)
            check($sformatf("h1_spacing%0d", i), 32'(t_cyc[i] - t_cyc[i-1]), 32'd3);
        for (int i = 0; i < t_cyc.size(); i++)
            if (t_cyc[i] + 1 < hist.size())
                check($sformatf("h1_width%0d", i), 32'(hist[t_cyc[i] + 1]), 32'h0);

        // ---- randomized run against the reference model ----
        apply_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) a_valid = ~a_valid;
            if ($urandom_range(0, 3) == 0) b_valid = ~b_valid;
            if ($urandom_range(0, 5) == 0) a_num = 16'($urandom);
            if ($urandom_range(0, 5) == 0) b_num = 16'($urandom);
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("rnd_ready_a", 32'(a_ready), 32'(m_offer == 1));
            check("rnd_ready_b", 32'(b_ready), 32'(m_offer == 2));
            check("rnd_number", 32'(number), 32'(m_num));
            check("rnd_owner", 32'(owner), 32'(m_owner));
            check("rnd_active", 32'(active), 32'(m_show_left > 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_share_arbiter.md
DISPLAY_SHARE_ARBITER -- requirements
Module: display_share_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 25000000, is the minimum clock cycles a granted number stays owned (1 s at 25 MHz); legal range 1..2^HOLD_WIDTH-1.
REQ-002 Parameter HOLD_WIDTH, default 25, is the width of the hold counter.
REQ-003 Port i_clk  input  1  single clock for all logic.
REQ-004 Port i_reset_n  input  1  reset, asynchronous and active-low.
REQ-005 Port i_req_a_valid  input  1  requester A has a number to show.
REQ-006 Port i_req_a_number  input  16  requester A number, four hex nibbles.
REQ-007 Port o_req_a_ready  output  1  registered; transfer from A occurs on a rising edge where valid and ready are both 1.
REQ-008 Ports i_req_b_valid (input, 1), i_req_b_number (input, 16) and o_req_b_ready (output, 1) SHALL mirror the A ports for requester B.
REQ-009 Port o_number_to_display  output  16  number driven to the downstream hex display wrapper.
REQ-010 Port o_owner  output  1  0 = A, 1 = B; owner of the current or last shown number.
REQ-011 Port o_active  output  1  high while a hold window is running.

Function
REQ-012 FSM states are IDLE, OFFER and SHOW; all outputs are registered.
REQ-013 IDLE: if any valid is 1, select a winner, enter OFFER and set the winner's ready to 1 on the same edge; otherwise stay in IDLE.
REQ-014 Winner rule: a single valid requester wins; if both are valid, the requester other than last_owner wins (round-robin).
REQ-015 OFFER, winner valid = 1 at the edge: transfer occurs. Capture the number into o_number_to_display, set o_owner and last_owner to the winner, clear ready, load the counter with HOLD_CYCLES-1, set o_active = 1 and enter SHOW.
REQ-016 OFFER, winner valid = 0 at the edge: no transfer. Clear ready, return to IDLE, and leave o_number_to_display, o_owner and last_owner unchanged.
REQ-017 At most one ready SHALL be high in any cycle, and a ready SHALL never be high outside OFFER.
REQ-018 Latency: valid sampled at edge E0 gives ready high after E0; transfer at E1; new number visible after E1.
REQ-019 SHOW: decrement the counter each cycle. At the edge where the counter equals 0, clear o_active and enter IDLE. SHOW therefore lasts exactly HOLD_CYCLES cycles.
REQ-020 During SHOW, requests are not acknowledged and there is no preemption. Pending valids wait and are arbitrated in IDLE.
REQ-021 With HOLD_CYCLES = 1, SHOW lasts one cycle.
REQ-022 Back-to-back requests: the minimum spacing between transfers is HOLD_CYCLES + 2 cycles (SHOW, then IDLE, then OFFER).
REQ-023 After SHOW, o_number_to_display keeps its last value until the next transfer; the display is never blanked.
REQ-024 Requesters SHALL hold valid and number stable from assertion until the transfer edge. A number that changes during OFFER is captured as sampled at the transfer edge.

Reset
REQ-025 While i_reset_n = 0, regardless of clock: state = IDLE, o_number_to_display = 16'h0000, o_owner = 0, o_active = 0, both readies = 0, counter = 0, last_owner = 1 (so A wins the first tie).
REQ-026 Reset asserted mid-OFFER or mid-SHOW SHALL abort with no transfer. Operation resumes from IDLE on the first clock edge after i_reset_n rises.

Verification (bench uses HOLD_CYCLES = 8, HOLD_WIDTH = 4)
REQ-027 Reset check: assert reset mid-SHOW -> immediately number = 0000, owner = 0, active = 0, both readies = 0.
REQ-028 Single request: A valid with 16'h12AB from cycle 0 -> a_ready high in cycle 1, number = 12AB and active = 1 from cycle 2, active = 0 after 8 cycles.
REQ-029 Tie after reset: A = 16'h1111 and B = 16'h2222 both valid and held -> A is served first, then B. The second transfer comes 10 cycles after the first and the owner toggles 0 -> 1.
REQ-030 Withdrawal: B valid for one cycle only -> b_ready pulses one cycle, no transfer, number and owner unchanged, FSM returns to IDLE.
REQ-031 Starvation check: A and B held valid continuously for 100 cycles -> grants strictly alternate, and a ready is never high while active = 1.
REQ-032 HOLD_CYCLES = 1 variant: continuous A requests -> a transfer every 3 cycles, with active high for exactly 1 cycle each.
